// File: rtl/window_pkg.sv
// window_pkg: shared helpers for the window generator.
//   clogb2  - ceil(log2(value)); 0 for value <= 1
//   state_t - per-row fill/run state encoding
//   pix_lsb - bit offset of pixel (r,c) in a row-major packed window
package window_pkg;

    typedef enum logic {FILL, RUN} state_t;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int pix_lsb(input int r, input int c, input int cols, input int data_width);
        return (r * cols + c) * data_width;
    endfunction

endpackage

// File: rtl/window_gen_column_shift.sv
// column_shift: column history for the window generator.
//   clk, rst  - clock, synchronous active-high clear of the history
//   shift_en  - accept col_in into the history
//   col_in    - aligned column, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//   win_nxt   - window as it stands once col_in is accepted (column 0 = col_in)
// Only LINE_NUM-1 past columns are stored: the newest column arrives on col_in
// and the caller's output register completes the LINE_NUM x LINE_NUM array.
module column_shift
    import window_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int LINE_NUM   = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     shift_en,
    input  logic [DATA_WIDTH*LINE_NUM-1:0]           col_in,
    output logic [DATA_WIDTH*LINE_NUM*LINE_NUM-1:0]  win_nxt
);

    localparam int HC = LINE_NUM - 1;

    logic [DATA_WIDTH*LINE_NUM*HC-1:0] hist;

    for (genvar r = 0; r < LINE_NUM; r++) begin : g_row
        for (genvar c = 0; c < LINE_NUM; c++) begin : g_col
            if (c == 0) begin : g_new
                assign win_nxt[pix_lsb(r, c, LINE_NUM, DATA_WIDTH) +: DATA_WIDTH] =
                    col_in[r*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_old
                assign win_nxt[pix_lsb(r, c, LINE_NUM, DATA_WIDTH) +: DATA_WIDTH] =
                    hist[pix_lsb(r, c - 1, HC, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else if (shift_en) begin
            for (int r = 0; r < LINE_NUM; r++)
                for (int c = 0; c < HC; c++)
                    hist[pix_lsb(r, c, HC, DATA_WIDTH) +: DATA_WIDTH] <=
                        win_nxt[pix_lsb(r, c, LINE_NUM, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/window_gen.sv
// window_gen: turns aligned columns into registered LINE_NUM x LINE_NUM windows.
//   clk, rst   - clock, synchronous active-high reset
//   col_in     - aligned column, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//   col_valid  - col_in accepted this cycle (no backpressure)
//   win_out    - window, pixel (r,c) at [(r*LINE_NUM+c)*DATA_WIDTH +: DATA_WIDTH], c=0 newest
//   win_valid  - one-cycle strobe per window fully inside the image
//   win_x, win_y, eol, eof - window coordinates and row/frame end flags,
//                present only when WINDOW_GEN_COORD_EN is defined
module window_gen
    import window_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int LINE_NUM     = 3,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [DATA_WIDTH*LINE_NUM-1:0]           col_in,
    input  logic                                     col_valid,
    output logic [DATA_WIDTH*LINE_NUM*LINE_NUM-1:0]  win_out,
`ifdef WINDOW_GEN_COORD_EN
    output logic [clogb2(IMAGE_WIDTH)-1:0]           win_x,
    output logic [clogb2(IMAGE_HEIGHT)-1:0]          win_y,
    output logic                                     eol,
    output logic                                     eof,
`endif
    output logic                                     win_valid
);

    localparam int CW = clogb2(IMAGE_WIDTH - 1) + 1;

    logic [CW-1:0]                              col_cnt;
    state_t                                     state, state_nxt;
    logic                                       last_col, emit;
    logic [DATA_WIDTH*LINE_NUM*LINE_NUM-1:0]    win_nxt;

    column_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_NUM   (LINE_NUM)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (col_valid),
        .col_in   (col_in),
        .win_nxt  (win_nxt)
    );

    assign last_col = col_cnt == CW'(IMAGE_WIDTH - 1);

    // The column that completes the first window of a row emits while still in FILL.
    always_comb begin
        emit      = col_valid && (state == RUN || col_cnt == CW'(LINE_NUM - 1));
        state_nxt = !col_valid ? state : last_col ? FILL : emit ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            col_cnt   <= '0;
            win_valid <= 1'b0;
            win_out   <= '0;
        end else begin
            state     <= state_nxt;
            win_valid <= emit;
            if (col_valid)
                col_cnt <= last_col ? '0 : col_cnt + 1'b1;
            if (emit)
                win_out <= win_nxt;
        end
    end

`ifdef WINDOW_GEN_COORD_EN
    localparam int ROWS = IMAGE_HEIGHT - LINE_NUM + 1;
    localparam int RW   = clogb2(ROWS - 1) + 1;
    localparam int XW   = clogb2(IMAGE_WIDTH);
    localparam int YW   = clogb2(IMAGE_HEIGHT);

    logic [RW-1:0] row_cnt;
    logic          last_row;

    assign last_row = row_cnt == RW'(ROWS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            win_x   <= '0;
            win_y   <= '0;
            eol     <= 1'b0;
            eof     <= 1'b0;
        end else begin
            eol <= emit && last_col;
            eof <= emit && last_col && last_row;
            if (col_valid && last_col)
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            if (emit) begin
                win_x <= XW'(col_cnt);
                win_y <= YW'(row_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed self-checking bench for window_gen (3x3 window, 8x6 image).
// Coordinate checks apply only when WINDOW_GEN_COORD_EN is defined.
module tb_window_gen;

    localparam int DW   = 14;
    localparam int L    = 3;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int ROWS = H - L + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              col_valid = 1'b0;
    logic [DW*L-1:0]   col_in = '0;
    logic [DW*L*L-1:0] win_out;
    logic              win_valid;
`ifdef WINDOW_GEN_COORD_EN
    logic [2:0]        win_x, win_y;
    logic              eol, eof;
`endif

    int tests = 0, fails = 0;
    int mcol = 0, mrow = 0, nwin = 0, neof = 0;
    logic [DW*L*L-1:0] last_win = '0;

    always #5 clk = ~clk;

    window_gen #(
        .DATA_WIDTH   (DW),
        .LINE_NUM     (L),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .col_valid (col_valid),
        .win_out   (win_out),
`ifdef WINDOW_GEN_COORD_EN
        .win_x     (win_x),
        .win_y     (win_y),
        .eol       (eol),
        .eof       (eof),
`endif
        .win_valid (win_valid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Column (row,col) carries 16*row+col+r on lane r.
    function automatic logic [DW*L-1:0] col_of(input int row, input int col);
        logic [DW*L-1:0] v;
        for (int r = 0; r < L; r++) v[r*DW +: DW] = DW'(16*row + col + r);
        return v;
    endfunction

    function automatic logic [DW*L*L-1:0] win_of(input int row, input int col);
        logic [DW*L*L-1:0] v;
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                v[(r*L + c)*DW +: DW] = DW'(16*row + col - c + r);
        return v;
    endfunction

    task automatic step(input bit v, input int row, input int col);
        @(negedge clk);
        col_valid = v;
        col_in    = col_of(row, col);
        @(posedge clk);
        #1;
        if (v && mcol >= L - 1) begin
            check("win_valid", win_valid, 1);
            check("win_out", win_out, win_of(row, col));
            last_win = win_of(row, col);
            nwin++;
`ifdef WINDOW_GEN_COORD_EN
            check("win_x", win_x, mcol);
            check("win_y", win_y, mrow);
            check("eol", eol, mcol == W - 1);
            check("eof", eof, mcol == W - 1 && mrow == ROWS - 1);
            if (eof) neof++;
`endif
        end else begin
            check("win_valid_idle", win_valid, 0);
            check("win_out_hold", win_out, last_win);
`ifdef WINDOW_GEN_COORD_EN
            check("eol_idle", eol, 0);
            check("eof_idle", eof, 0);
`endif
        end
        if (v) begin
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic reset_dut(input bit v, input int row, input int col);
        @(negedge clk);
        rst       = 1'b1;
        col_valid = v;
        col_in    = col_of(row, col);
        @(posedge clk);
        #1;
        check("rst_valid", win_valid, 0);
        check("rst_win", win_out, 0);
`ifdef WINDOW_GEN_COORD_EN
        check("rst_x", win_x, 0);
        check("rst_y", win_y, 0);
        check("rst_eol", eol, 0);
        check("rst_eof", eof, 0);
`endif
        mcol     = 0;
        mrow     = 0;
        last_win = '0;
        @(negedge clk);
        rst       = 1'b0;
        col_valid = 1'b0;
    endtask

    initial begin
        reset_dut(0, 0, 0);

        // Continuous frame, including back-to-back row boundaries.
        nwin = 0;
        neof = 0;
        for (int row = 0; row < ROWS; row++)
            for (int col = 0; col < W; col++)
                step(1, row, col);
        check("frame_windows", nwin, 24);
`ifdef WINDOW_GEN_COORD_EN
        check("frame_eof", neof, 1);
`endif

        // Same frame with col_valid toggling 1-0.
        nwin = 0;
        for (int row = 0; row < ROWS; row++)
            for (int col = 0; col < W; col++) begin
                step(1, row, col);
                step(0, row, col);
            end
        check("gapped_windows", nwin, 24);

        // Reset after column 4 of row 1; the next row restarts at row 0, column 0.
        for (int col = 0; col < W; col++) step(1, 0, col);
        for (int col = 0; col < 5; col++) step(1, 1, col);
        reset_dut(0, 0, 0);
        nwin = 0;
        for (int col = 0; col < W; col++) step(1, 9, col);
        check("post_rst_windows", nwin, 6);

        // Reset coinciding with a valid column: that column must be dropped.
        for (int col = 0; col < 4; col++) step(1, 5, col);
        reset_dut(1, 12, 0);
        nwin = 0;
        for (int col = 0; col < 3; col++) step(1, 13, col);
        check("rst_drop_windows", nwin, 1);

        col_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_gen.md
# window_gen

Converts the column stream produced by the line-alignment stage into a LINE_NUM x LINE_NUM pixel window per cycle. Each accepted column is LINE_NUM vertically aligned pixels. The block holds the last LINE_NUM columns in a shift array and tracks column and row position within the frame. It emits a registered window with a valid strobe only where the window lies fully inside the image. It sits directly downstream of the line aligner and feeds the filter/kernel stages.

## Interface
Parameters:
- DATA_WIDTH, 14, bits per pixel
- LINE_NUM, 3, window height and width (≥2)
- IMAGE_WIDTH, 128, pixels per line
- IMAGE_HEIGHT, 128, lines per frame

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous, active-high
- col_in  in  DATA_WIDTH*LINE_NUM  aligned column; lane r = col_in[r*DATA_WIDTH +: DATA_WIDTH]
- col_valid  in  1  col_in is valid this cycle; no backpressure
- win_out  out  DATA_WIDTH*LINE_NUM*LINE_NUM  window; pixel (r,c) at [(r*LINE_NUM+c)*DATA_WIDTH +: DATA_WIDTH]; c=0 newest column
- win_valid  out  1  win_out valid, one-cycle strobe per window
- win_x  out  clogb2(IMAGE_WIDTH)  column index of the newest column in the window (macro-gated)
- win_y  out  clogb2(IMAGE_HEIGHT)  aligned-row index, 0-based (macro-gated)
- eol  out  1  with win_valid on the last window of a row (macro-gated)
- eof  out  1  with win_valid on the last window of a frame (macro-gated)

## Operation
- Shift array: on col_valid, column c becomes column c-1's previous value (c=1..LINE_NUM-1), and column 0 takes col_in. The array holds when col_valid is low.
- col_cnt: counts 0..IMAGE_WIDTH-1 and increments on each col_valid. On col_valid at IMAGE_WIDTH-1 it wraps to 0 and row_cnt increments.
- row_cnt: counts 0..ROWS-1, where ROWS = IMAGE_HEIGHT-LINE_NUM+1 (the aligned rows the aligner delivers per frame). It wraps to 0 after the last row.
- Per-row FSM:
  - FILL: while col_cnt < LINE_NUM-1, no output.
  - On the accepted column with col_cnt = LINE_NUM-1, go to RUN. In RUN, every accepted column yields a window.
  - On the wrap of col_cnt, return to FILL. Shift contents are not cleared; stale columns are never emitted because FILL suppresses output.
- Windows per row: IMAGE_WIDTH-LINE_NUM+1. Windows per frame: that value times ROWS.
- Counter widths come from clogb2(N-1)+1. Compares are unsigned. No arithmetic on pixel data.
- Reset (any cycle, including mid-row or mid-frame):
  - col_cnt, row_cnt and the shift array go to 0, and the FSM goes to FILL.
  - All outputs go to 0 on the next edge.
  - The next col_valid is treated as column 0 of row 0.
- Gaps in col_valid anywhere, including across row boundaries, are tolerated. Position advances only on accepted columns.

## Timing
- Latency: 1 cycle. A window completed by the column accepted on edge N is presented, with win_valid=1, after edge N, i.e. during cycle N+1.
- win_out and the coordinate outputs hold their last value when win_valid=0. win_valid itself deasserts.
- Back-to-back col_valid in RUN gives continuous win_valid.
- Simultaneous rst and col_valid: rst wins and the column is dropped.
- eol/eof assert only together with win_valid. At the final column of the frame, eol=eof=1.

## Configuration
- WINDOW_GEN_COORD_EN defined: win_x, win_y, eol and eof ports exist and are driven as above.
- WINDOW_GEN_COORD_EN undefined: those four ports are absent. row_cnt is not implemented; col_cnt and the FSM remain. win_out and win_valid are cycle-identical to the enabled build.

## Structure
- Shared package window_pkg:
  - clogb2 function
  - FSM state encoding (FILL, RUN)
  - window lane-index helper constant (LINE_NUM-based offset)
- One sub-module, column_shift: the LINE_NUM x LINE_NUM register array with shift-enable and sync clear. window_gen holds the counters, the FSM and the output registers.

## Test plan
All tests use LINE_NUM=3, IMAGE_WIDTH=8, IMAGE_HEIGHT=6, DATA_WIDTH=14.
- Continuous frame: 4 rows x 8 columns, lane r = 16*row+col+r. Expect 24 win_valid strobes.
  - First window at win_x=2, win_y=0, with pixel(0,0)=2 and pixel(0,2)=0.
  - eol on win_x=7; eof exactly once at win_x=7, win_y=3.
- Gapped input: the same frame with col_valid toggling 1-0. Expect identical window contents and coordinates. win_valid occurs only on the cycle after each accepted column.
- Row boundary: columns 7 of row 0 and 0 of row 1 are back-to-back. Expect no window containing pixels from both rows, and the next strobe at win_x=2, win_y=1.
- Reset mid-row: assert rst after column 4 of row 1. Expect all outputs 0 the following cycle. The next 8 columns produce windows with win_y=0 and first win_x=2.
- Simultaneous rst and col_valid: the column is dropped. A subsequent 3 columns give exactly one window, containing only post-reset data.
- Build without WINDOW_GEN_COORD_EN: rerun the continuous-frame test. win_out and win_valid traces must match the enabled build bit-for-bit.
